instr_loader: RTL and testbench

Sequential instruction encoder and loader for the 16-bit CPU. It accepts decoded instruction fields (opcode, Rx, Ry, immediate) over a valid/ready stream and packs them into 16-bit instruction words in the format the CPU's opcode decoder consumes. Each legal word is written to consecutive instruction-memory addresses, starting from a programmable base. While a load is in progress it holds the CPU in reset.

---
 rtl/instr_loader_if.sv | 24 ++
 rtl/instr_loader.sv | 121 ++++++++++++
 tb/tb_instr_loader.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/instr_loader_if.sv
// Field-bundle stream into the loader and the instruction-memory write port out of it.
interface instr_loader_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_opcode;
    logic [2:0]        in_rx;
    logic [2:0]        in_ry;
    logic [10:0]       in_imm;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;

    modport master (
        output in_valid, in_opcode, in_rx, in_ry, in_imm,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_opcode, in_rx, in_ry, in_imm,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instr_loader.sv
// Packs decoded instruction fields into 16-bit words and writes them to consecutive
// instruction-memory addresses, holding the CPU in reset for the duration of the load.
module instr_loader #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  length,
    input  logic              abort,
    instr_loader_if.slave     bus,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  err_count
);
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  errcnt_q, errcnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [15:0]       wdata_q, wdata_d;

    logic        accept, legal_op, imm_ok, legal;
    logic [15:0] word;

    assign bus.in_ready = (state_q == LOAD) && !abort;
    assign accept       = bus.in_valid && bus.in_ready;

    assign legal_op = bus.in_opcode inside {
        5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
        5'b01000, 5'b01001, 5'b01010, 5'b01100,
        5'b10000, 5'b10001, 5'b10010, 5'b10011, 5'b10110,
        5'b11000, 5'b11001, 5'b11010, 5'b11100};
    // Imm8 forms only carry eight immediate bits; anything above must be zero.
    assign imm_ok = !((bus.in_opcode[4:3] == 2'b10) && (bus.in_imm[10:8] != 3'b000));
    assign legal  = legal_op && imm_ok;

    always_comb begin
        unique case (bus.in_opcode[4:3])
            2'b00:   word = {5'b0, bus.in_ry, bus.in_rx, bus.in_opcode};
            2'b01:   word = {8'b0, bus.in_rx, bus.in_opcode};
            2'b10:   word = {bus.in_imm[7:0], bus.in_rx, bus.in_opcode};
            default: word = {bus.in_imm, bus.in_opcode};
        endcase
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        err_d    = err_q;
        errcnt_d = errcnt_q;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d   = base_addr;
                    rem_d    = length;
                    err_d    = 1'b0;
                    errcnt_d = '0;
                    state_d  = (length == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = DONE;
                end else if (accept && legal) begin
                    we_d    = 1'b1;
                    waddr_d = addr_q;
                    wdata_d = word;
                    addr_d  = addr_q + ADDR_W'(1);
                    rem_d   = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) state_d = DONE;
                end else if (accept) begin
                    err_d = 1'b1;
                    if (errcnt_q != '1) errcnt_d = errcnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            rem_q    <= '0;
            err_q    <= 1'b0;
            errcnt_q <= '0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            err_q    <= err_d;
            errcnt_q <= errcnt_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = waddr_q;
    assign bus.mem_wdata = wdata_q;
    assign cpu_hold      = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign err           = err_q;
    assign err_count     = errcnt_q;
endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: hand-encoded words, write log, FSM and error flags.
module tb_instr_loader;
    logic       clk = 1'b0;
    logic       reset, start, abort;
    logic [7:0] base_addr, length;
    logic       cpu_hold, done, err;
    logic [7:0] err_count;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [23:0] wq[$];

    instr_loader_if #(.ADDR_W(8)) bus ();

    instr_loader #(.ADDR_W(8), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .length(length), .abort(abort), .bus(bus), .cpu_hold(cpu_hold),
        .done(done), .err(err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Every cycle with mem_we high logs one {addr, data} entry.
    always @(negedge clk) if (bus.mem_we) wq.push_back({bus.mem_addr, bus.mem_wdata});

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_load(input logic [7:0] b, input logic [7:0] n);
        wq.delete();
        base_addr = b;
        length    = n;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    task automatic send(input logic [4:0] op, input logic [2:0] rx, input logic [2:0] ry,
                        input logic [10:0] imm);
        bus.in_valid  = 1'b1;
        bus.in_opcode = op;
        bus.in_rx     = rx;
        bus.in_ry     = ry;
        bus.in_imm    = imm;
        step();
    endtask

    task automatic chk_wr(input string tag, input int idx, input logic [7:0] a,
                          input logic [15:0] d);
        chk(tag, (idx < wq.size()) ? {8'h0, wq[idx]} : 32'hFFFF_FFFF, {8'h0, a, d});
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; base_addr = '0; length = '0;
        bus.in_valid = 1'b0; bus.in_opcode = '0; bus.in_rx = '0; bus.in_ry = '0; bus.in_imm = '0;
        step(); step();
        chk("rst_ready", bus.in_ready, 0);
        chk("rst_we", bus.mem_we, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_wdata", bus.mem_wdata, 0);
        chk("rst_hold", cpu_hold, 0);
        chk("rst_done", done, 0);
        chk("rst_err", {err, err_count}, 0);
        reset = 1'b0;
        step();

        // Three forms back-to-back
        begin_load(8'h10, 8'd3);
        chk("t1_ready", bus.in_ready, 1);
        chk("t1_hold", cpu_hold, 1);
        send(5'b00001, 3'd1, 3'd2, 11'h0);
        chk("t1_lat_we", bus.mem_we, 1);
        send(5'b10000, 3'd3, 3'd0, 11'h07F);
        send(5'b11000, 3'd0, 3'd0, 11'h400);
        bus.in_valid = 1'b0;
        chk("t1_done", done, 1);
        chk("t1_last_we", {bus.mem_we, bus.mem_addr}, {1'b1, 8'h12});
        step();
        chk("t1_done_off", {done, cpu_hold}, 0);
        chk("t1_nwr", wq.size(), 3);
        chk_wr("t1_w0", 0, 8'h10, 16'h0221);
        chk_wr("t1_w1", 1, 8'h11, 16'h7F70);
        chk_wr("t1_w2", 2, 8'h12, 16'h8018);
        chk("t1_err", err, 0);

        // Illegal opcode consumed, then register and register-jump forms
        begin_load(8'h20, 8'd2);
        send(5'b00111, 3'd1, 3'd1, 11'h0);
        chk("t2_rej_we", bus.mem_we, 0);
        send(5'b00010, 3'd0, 3'd5, 11'h0);
        send(5'b01000, 3'd6, 3'd7, 11'h0);
        bus.in_valid = 1'b0;
        chk("t2_done", done, 1);
        chk("t2_err", {err, err_count}, {1'b1, 8'd1});
        step();
        chk("t2_nwr", wq.size(), 2);
        chk_wr("t2_w0", 0, 8'h20, 16'h0502);
        chk_wr("t2_w1", 1, 8'h21, 16'h00C8);

        // Imm8 out of range
        begin_load(8'h30, 8'd1);
        chk("t3_err_clr", {err, err_count}, 0);
        send(5'b10001, 3'd2, 3'd0, 11'h1FF);
        chk("t3_rej", {err, err_count, bus.mem_we, done}, {1'b1, 8'd1, 1'b0, 1'b0});
        send(5'b10001, 3'd2, 3'd0, 11'h0FF);
        bus.in_valid = 1'b0;
        chk("t3_done", done, 1);
        step();
        chk("t3_nwr", wq.size(), 1);
        chk_wr("t3_w0", 0, 8'h30, 16'hFF51);

        // Address wrap
        begin_load(8'hFF, 8'd2);
        chk("t4_err_clr", {err, err_count}, 0);
        send(5'b00000, 3'd1, 3'd0, 11'h0);
        send(5'b00000, 3'd2, 3'd0, 11'h0);
        bus.in_valid = 1'b0;
        step();
        chk("t4_nwr", wq.size(), 2);
        chk_wr("t4_w0", 0, 8'hFF, 16'h0020);
        chk_wr("t4_w1", 1, 8'h00, 16'h0040);

        // Abort after two accepts with in_valid held
        begin_load(8'h00, 8'd5);
        send(5'b00000, 3'd1, 3'd0, 11'h0);
        step();
        abort = 1'b1;
        #1;
        chk("t5_ready_abort", bus.in_ready, 0);
        chk("t5_inflight", bus.mem_we, 1);
        step();
        abort = 1'b0;
        chk("t5_done", {done, bus.mem_we, bus.in_ready}, 3'b100);
        step();
        bus.in_valid = 1'b0;
        chk("t5_hold_off", {cpu_hold, done}, 0);
        chk("t5_nwr", wq.size(), 2);
        chk_wr("t5_w1", 1, 8'h01, 16'h0020);

        // Reset mid-load
        begin_load(8'h00, 8'd5);
        send(5'b00000, 3'd1, 3'd0, 11'h0);
        step();
        reset = 1'b1;
        bus.in_valid = 1'b0;
        step();
        chk("t6_rst_outs", {bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, cpu_hold, done, err, err_count},
            '0);
        reset = 1'b0;
        step();

        // Zero length
        begin_load(8'h50, 8'd0);
        chk("t7_zero", {done, bus.in_ready, cpu_hold}, 3'b101);
        step();
        chk("t7_idle", {done, cpu_hold}, 0);

        // Start during LOAD is ignored
        begin_load(8'h40, 8'd2);
        send(5'b00000, 3'd1, 3'd0, 11'h0);
        bus.in_valid = 1'b0;
        base_addr = 8'h80; length = 8'd5; start = 1'b1;
        step();
        start = 1'b0;
        send(5'b00000, 3'd2, 3'd0, 11'h0);
        bus.in_valid = 1'b0;
        chk("t8_done", {done, bus.mem_addr}, {1'b1, 8'h41});
        step();
        chk("t8_nwr", wq.size(), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
